// File: rtl/dm_be.sv
// Byte-enabled data memory with a post-reset clear sweep and alignment checking.
// Optional store trace: define DM_TRACE_EN.
module dm_be #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] addr,
  input  logic [1:0]  mem_op,
  input  logic        load_unsigned,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        busy,
  output logic        align_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic                  state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  align_err_q, align_err_d;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           rd_word;
  logic [31:0]           wr_word;
  logic [31:0]           ld_word;
  logic [15:0]           ld_half;
  logic [7:0]            ld_byte;
  logic                  misalign;
  logic                  st_en;

  // Upper address bits alias onto the array; pc only matters for the trace.
  logic unused_bits;
  assign unused_bits = ^{pc, addr[31:DEPTH_LOG2+2]};

  assign widx    = addr[DEPTH_LOG2+1:2];
  assign rd_word = mem_q[widx];
  assign busy    = (state_q == ST_CLEAR);

  always_comb begin
    misalign = 1'b0;
    if (MemWrite || MemRead) begin
      unique case (mem_op)
        2'b00:   misalign = (addr[1:0] != 2'b00);
        2'b01:   misalign = addr[0];
        2'b10:   misalign = 1'b0;
        default: misalign = 1'b1;
      endcase
    end
  end

  assign st_en = MemWrite && !busy && !misalign && !reset;

  // Merge store data into the current word so only the addressed lanes change.
  always_comb begin
    wr_word = rd_word;
    unique case (mem_op)
      2'b00: wr_word = din;
      2'b01: begin
        if (addr[1]) wr_word[31:16] = din[15:0];
        else         wr_word[15:0]  = din[15:0];
      end
      2'b10:   wr_word[{addr[1:0], 3'b000} +: 8] = din[7:0];
      default: wr_word = rd_word;
    endcase
  end

  always_comb begin
    ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    unique case (mem_op)
      2'b00:   ld_word = rd_word;
      2'b01:   ld_word = {{16{~load_unsigned & ld_half[15]}}, ld_half};
      2'b10:   ld_word = {{24{~load_unsigned & ld_byte[7]}}, ld_byte};
      default: ld_word = '0;
    endcase
  end

  assign dout      = busy ? '0 : ld_word;
  assign align_err = align_err_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    align_err_d = misalign;
    if (reset) begin
      state_d     = ST_CLEAR;
      clr_ptr_d   = '0;
      align_err_d = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + DEPTH_LOG2'(1);
      if (clr_ptr_q == '1) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clr_ptr_q   <= clr_ptr_d;
    align_err_q <= align_err_d;
  end

  // Array has no reset so it can map to block RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (st_en) begin
        mem_q[widx] <= wr_word;
`ifdef DM_TRACE_EN
        $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, wr_word);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dm_be.sv
// Directed self-checking bench for dm_be with DEPTH_LOG2=4.
module tb_dm_be;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] addr;
  logic [1:0]  mem_op;
  logic        load_unsigned;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        align_err;

  int ncmp  = 0;
  int nfail = 0;

  dm_be #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .MemWrite(MemWrite), .MemRead(MemRead),
    .addr(addr), .mem_op(mem_op), .load_unsigned(load_unsigned), .din(din),
    .dout(dout), .busy(busy), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge, checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [1:0] op, input logic uns, input logic [31:0] d);
    MemWrite = wr; MemRead = rd; addr = a; mem_op = op; load_unsigned = uns; din = d;
    pc = pc + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL reset_busy[%0d]: got %b want 1", i, busy); end
      ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL reset_dout[%0d]: got %h want 00000000", i, dout); end
      ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL reset_aerr[%0d]: got %b want 0", i, align_err); end
      tick();
    end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_done: busy got %b want 0", busy); end
    for (int w = 0; w < 16; w++) begin
      drive(1'b0, 1'b1, 32'(w * 4), 2'b00, 1'b0, 32'h0);
      ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL clear_word[%0d]: got %h want 00000000", w, dout); end
    end
  endtask

  task automatic test_word();
    drive(1'b1, 1'b1, 32'h08, 2'b00, 1'b0, 32'h12345678);
    ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL sw_same_cycle: got %h want 00000000", dout); end
    tick();
    drive(1'b0, 1'b1, 32'h08, 2'b00, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'h12345678) begin nfail++; $display("FAIL lw08: got %h want 12345678", dout); end
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL sw_aerr: got %b want 0", align_err); end
  endtask

  task automatic test_byte();
    drive(1'b1, 1'b0, 32'h09, 2'b10, 1'b0, 32'h000000FF);
    tick();
    drive(1'b0, 1'b1, 32'h08, 2'b00, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'h1234FF78) begin nfail++; $display("FAIL sb_lw08: got %h want 1234FF78", dout); end
    drive(1'b0, 1'b1, 32'h09, 2'b10, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'hFFFFFFFF) begin nfail++; $display("FAIL lb09: got %h want FFFFFFFF", dout); end
    drive(1'b0, 1'b1, 32'h09, 2'b10, 1'b1, 32'h0);
    ncmp++; if (dout !== 32'h000000FF) begin nfail++; $display("FAIL lbu09: got %h want 000000FF", dout); end
    drive(1'b0, 1'b1, 32'h0B, 2'b10, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'h00000012) begin nfail++; $display("FAIL lb0B: got %h want 00000012", dout); end
  endtask

  task automatic test_half();
    drive(1'b1, 1'b0, 32'h02, 2'b01, 1'b0, 32'h00008001);
    tick();
    drive(1'b0, 1'b1, 32'h00, 2'b00, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'h80010000) begin nfail++; $display("FAIL sh_lw00: got %h want 80010000", dout); end
    drive(1'b0, 1'b1, 32'h02, 2'b01, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'hFFFF8001) begin nfail++; $display("FAIL lh02: got %h want FFFF8001", dout); end
    drive(1'b0, 1'b1, 32'h02, 2'b01, 1'b1, 32'h0);
    ncmp++; if (dout !== 32'h00008001) begin nfail++; $display("FAIL lhu02: got %h want 00008001", dout); end
    drive(1'b0, 1'b1, 32'h08, 2'b01, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'hFFFFFF78) begin nfail++; $display("FAIL lh08: got %h want FFFFFF78", dout); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 32'h06, 2'b00, 1'b0, 32'hDEADBEEF);
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL mis_pre: got %b want 0", align_err); end
    tick();
    drive(1'b0, 1'b1, 32'h04, 2'b00, 1'b0, 32'h0);
    ncmp++; if (align_err !== 1'b1) begin nfail++; $display("FAIL mis_pulse: got %b want 1", align_err); end
    ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL mis_mem04: got %h want 00000000", dout); end
    tick();
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL mis_end: got %b want 0", align_err); end
    drive(1'b1, 1'b0, 32'h08, 2'b11, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h08, 2'b00, 1'b0, 32'h0);
    ncmp++; if (align_err !== 1'b1) begin nfail++; $display("FAIL rsv_pulse: got %b want 1", align_err); end
    ncmp++; if (dout !== 32'h1234FF78) begin nfail++; $display("FAIL rsv_mem08: got %h want 1234FF78", dout); end
    tick();
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL rsv_end: got %b want 0", align_err); end
    // Back-to-back: misaligned store then misaligned half load.
    drive(1'b1, 1'b0, 32'h01, 2'b01, 1'b0, 32'hFFFF);
    tick();
    drive(1'b0, 1'b1, 32'h03, 2'b00, 1'b0, 32'h0);
    ncmp++; if (align_err !== 1'b1) begin nfail++; $display("FAIL b2b_first: got %b want 1", align_err); end
    tick();
    drive(1'b0, 1'b1, 32'h00, 2'b00, 1'b0, 32'h0);
    ncmp++; if (align_err !== 1'b1) begin nfail++; $display("FAIL b2b_hold: got %b want 1", align_err); end
    ncmp++; if (dout !== 32'h80010000) begin nfail++; $display("FAIL b2b_mem00: got %h want 80010000", dout); end
    tick();
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL b2b_end: got %b want 0", align_err); end
    // Misaligned address with neither strobe is not checked.
    drive(1'b0, 1'b0, 32'h07, 2'b00, 1'b0, 32'h0);
    tick();
    ncmp++; if (align_err !== 1'b0) begin nfail++; $display("FAIL idle_nochk: got %b want 0", align_err); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL mid_busy5: got %b want 1", busy); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0C, 2'b00, 1'b0, 32'hDEADBEEF);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL mid_busy[%0d]: got %b want 1", i, busy); end
      ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL mid_dout[%0d]: got %h want 00000000", i, dout); end
      tick();
    end
    drive(1'b0, 1'b1, 32'h0C, 2'b00, 1'b0, 32'h0);
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL mid_done: busy got %b want 0", busy); end
    ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL mid_drop0C: got %h want 00000000", dout); end
    drive(1'b0, 1'b1, 32'h08, 2'b00, 1'b0, 32'h0);
    ncmp++; if (dout !== 32'h0) begin nfail++; $display("FAIL mid_clr08: got %h want 00000000", dout); end
  endtask

  initial begin
    pc = 32'h0; reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; addr = '0;
    mem_op = 2'b00; load_unsigned = 1'b0; din = '0;
    #2;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
